sdram_wb_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single sdram_top Wishbone SDRAM slave port between NM masters.

---
 rtl/sdram_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_sdram_wb_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_arbiter.sv
// Round-robin Wishbone arbiter: shares one sdram_top slave port between NM masters,
// forwarding the granted master's bus combinationally and bounding grant length with MAX_HOLD.
module sdram_wb_arbiter #(
    parameter int NM       = 2,
    parameter int GW       = 1,
    parameter int AW       = 32,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NM*AW-1:0]  wbm_address,
    input  logic [NM*DW-1:0]  wbm_writedata,
    input  logic [NM-1:0]     wbm_strobe,
    input  logic [NM-1:0]     wbm_cycle,
    input  logic [NM-1:0]     wbm_write,
    output logic [NM-1:0]     wbm_ack,
    output logic [DW-1:0]     wbm_readdata,
    output logic [AW-1:0]     wbs_sdram_address,
    output logic [DW-1:0]     wbs_sdram_writedata,
    input  logic [DW-1:0]     wbs_sdram_readdata,
    output logic              wbs_sdram_strobe,
    output logic              wbs_sdram_cycle,
    output logic              wbs_sdram_write,
    input  logic              wbs_sdram_ack,
    output logic              grant_valid,
    output logic [GW-1:0]     grant_idx
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t         state, state_next;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  pick_idx;
    logic           pick_found;
    logic [HW-1:0]  hold_cnt, hold_next;
    logic [NM-1:0]  grant_mask;
    logic           others_req;

    // Round-robin search starting just after the previous owner, wrapping modulo NM.
    always_comb begin
        logic [GW:0]   sum;
        logic [GW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        cand       = '0;
        for (int k = 1; k <= NM; k++) begin
            sum = {1'b0, last_grant} + (GW+1)'(k);
            if (sum >= (GW+1)'(NM))
                sum = sum - (GW+1)'(NM);
            cand = sum[GW-1:0];
            if (!pick_found && wbm_cycle[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_mask            = '0;
        grant_mask[grant_idx] = 1'b1;
        others_req            = |(wbm_cycle & ~grant_mask);
        if (wbs_sdram_ack && hold_cnt != HW'(MAX_HOLD))
            hold_next = hold_cnt + 1'b1;
        else
            hold_next = hold_cnt;
    end

    // NOTE: every output of this block gets a default before the case; a missing
    // assignment on any path would otherwise infer a latch.
    always_comb begin
        state_next          = state;
        wbs_sdram_address   = '0;
        wbs_sdram_writedata = '0;
        wbs_sdram_strobe    = 1'b0;
        wbs_sdram_cycle     = 1'b0;
        wbs_sdram_write     = 1'b0;
        wbm_ack             = '0;
        wbm_readdata        = '0;
        case (state)
            IDLE: begin
                if (pick_found)
                    state_next = GRANT;
            end
            GRANT: begin
                wbs_sdram_address   = wbm_address[int'(grant_idx)*AW +: AW];
                wbs_sdram_writedata = wbm_writedata[int'(grant_idx)*DW +: DW];
                wbs_sdram_strobe    = wbm_strobe[grant_idx];
                wbs_sdram_cycle     = wbm_cycle[grant_idx];
                wbs_sdram_write     = wbm_write[grant_idx];
                wbm_ack[grant_idx]  = wbs_sdram_ack;
                wbm_readdata        = wbs_sdram_readdata;
                if (!wbm_cycle[grant_idx])
                    state_next = RELEASE;
                // Forced release only on an ack edge, so no transfer is cut short.
                else if (MAX_HOLD != 0 && wbs_sdram_ack &&
                         hold_next == HW'(MAX_HOLD) && others_req)
                    state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_grant  <= GW'(NM - 1);
            hold_cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                    end
                end
                GRANT:   hold_cnt <= hold_next;
                RELEASE: begin
                    last_grant  <= grant_idx;
                    hold_cnt    <= '0;
                    grant_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench for sdram_wb_arbiter: transaction-level arbiter model checked every
// cycle, a fixed-latency slave, master BFMs and directed scenarios with literal expectations.
module tb_sdram_wb_arbiter;

    localparam int NM = 2, GW = 1, AW = 32, DW = 16, MAX_HOLD = 4, LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM*AW-1:0]  wbm_address;
    logic [NM*DW-1:0]  wbm_writedata;
    logic [NM-1:0]     wbm_strobe, wbm_cycle, wbm_write;
    logic [NM-1:0]     wbm_ack;
    logic [DW-1:0]     wbm_readdata;
    logic [AW-1:0]     wbs_sdram_address;
    logic [DW-1:0]     wbs_sdram_writedata;
    logic [DW-1:0]     wbs_sdram_readdata;
    logic              wbs_sdram_strobe, wbs_sdram_cycle, wbs_sdram_write, wbs_sdram_ack;
    logic              grant_valid;
    logic [GW-1:0]     grant_idx;

    sdram_wb_arbiter #(.NM(NM), .GW(GW), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .wbm_address(wbm_address), .wbm_writedata(wbm_writedata),
        .wbm_strobe(wbm_strobe), .wbm_cycle(wbm_cycle), .wbm_write(wbm_write),
        .wbm_ack(wbm_ack), .wbm_readdata(wbm_readdata),
        .wbs_sdram_address(wbs_sdram_address), .wbs_sdram_writedata(wbs_sdram_writedata),
        .wbs_sdram_readdata(wbs_sdram_readdata), .wbs_sdram_strobe(wbs_sdram_strobe),
        .wbs_sdram_cycle(wbs_sdram_cycle), .wbs_sdram_write(wbs_sdram_write),
        .wbs_sdram_ack(wbs_sdram_ack), .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    // Slave: acks LAT cycles after it first sees a request, one-cycle ack pulse.
    logic          s_req;
    logic [AW-1:0] s_addr;
    int            s_cnt;
    always @(negedge clk) begin
        s_req  = wbs_sdram_cycle && wbs_sdram_strobe;
        s_addr = wbs_sdram_address;
    end
    initial begin
        wbs_sdram_ack      = 1'b0;
        wbs_sdram_readdata = 16'hDEAD;
        s_cnt              = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || wbs_sdram_ack || !s_req) begin
                wbs_sdram_ack      = 1'b0;
                wbs_sdram_readdata = 16'hDEAD;
                s_cnt              = 0;
            end else begin
                s_cnt++;
                if (s_cnt == LAT) begin
                    wbs_sdram_ack      = 1'b1;
                    wbs_sdram_readdata = rd_of(s_addr);
                    s_cnt              = 0;
                end
            end
        end
    end

    // Arbiter model: owner (-1 = nobody), a pending one-cycle release gap, last owner, acks this grant.
    bit          mon_en = 1'b0;
    int          m_owner = -1;
    bit          m_rel = 1'b0;
    int          m_holder = 0;
    int          m_last = NM - 1;
    int          m_acks = 0;
    logic [NM-1:0] exp_ack;
    bit          gv_prev = 1'b0;
    int          glog[$];
    int          alog[$];

    always @(negedge clk) begin
        if (mon_en) begin
            exp_ack = '0;
            if (m_owner >= 0) begin
                check("grant_valid", grant_valid, 1);
                check("grant_idx", grant_idx, m_owner);
                check("ds_cycle", wbs_sdram_cycle, wbm_cycle[m_owner]);
                check("ds_strobe", wbs_sdram_strobe, wbm_strobe[m_owner]);
                check("ds_write", wbs_sdram_write, wbm_write[m_owner]);
                check("ds_address", wbs_sdram_address, wbm_address[m_owner*AW +: AW]);
                check("ds_writedata", wbs_sdram_writedata, wbm_writedata[m_owner*DW +: DW]);
                check("readdata", wbm_readdata, wbs_sdram_readdata);
                exp_ack[m_owner] = wbs_sdram_ack;
            end else begin
                check("grant_valid", grant_valid, m_rel);
                if (m_rel)
                    check("grant_idx_rel", grant_idx, m_holder);
                check("ds_cycle_idle", wbs_sdram_cycle, 0);
                check("ds_strobe_idle", wbs_sdram_strobe, 0);
                check("ds_write_idle", wbs_sdram_write, 0);
            end
            check("wbm_ack", wbm_ack, exp_ack);

            if (grant_valid && !gv_prev) begin
                glog.push_back(int'(grant_idx));
                alog.push_back(0);
            end
            if (|wbm_ack && alog.size() > 0)
                alog[alog.size()-1] += 1;
            gv_prev = grant_valid;

            if (reset) begin
                m_owner = -1; m_rel = 1'b0; m_last = NM - 1; m_acks = 0;
            end else if (m_rel) begin
                m_rel = 1'b0; m_last = m_holder; m_acks = 0;
            end else if (m_owner < 0) begin
                for (int k = 1; k <= NM; k++) begin
                    if (m_owner < 0 && wbm_cycle[(m_last + k) % NM]) begin
                        m_owner  = (m_last + k) % NM;
                        m_holder = m_owner;
                    end
                end
            end else begin
                int  a;
                bit  others;
                a = m_acks + (wbs_sdram_ack ? 1 : 0);
                if (a > MAX_HOLD) a = MAX_HOLD;
                others = 1'b0;
                for (int j = 0; j < NM; j++)
                    if (j != m_owner && wbm_cycle[j]) others = 1'b1;
                if (!wbm_cycle[m_owner] ||
                    (MAX_HOLD != 0 && wbs_sdram_ack && a == MAX_HOLD && others)) begin
                    m_rel   = 1'b1;
                    m_owner = -1;
                end
                m_acks = a;
            end
        end
    end

    task automatic master_run(input int m, input int n, input bit wr, input logic [AW-1:0] base);
        int got = 0;
        int budget = 0;
        @(posedge clk);
        #1;
        wbm_cycle[m] = 1'b1;
        wbm_strobe[m] = 1'b1;
        wbm_write[m] = wr;
        wbm_address[m*AW +: AW] = base;
        wbm_writedata[m*DW +: DW] = base[DW-1:0] ^ 16'h1234;
        while (got < n && budget < 300) begin
            @(negedge clk);
            budget++;
            if (wbm_ack[m]) begin
                if (!wr)
                    check($sformatf("m%0d_rdata_%0d", m, got), wbm_readdata, rd_of(base + AW'(got)));
                got++;
                @(posedge clk);
                #1;
                if (got < n) begin
                    wbm_address[m*AW +: AW] = base + AW'(got);
                    wbm_writedata[m*DW +: DW] = base[DW-1:0] ^ 16'h1234 ^ DW'(got);
                end else begin
                    wbm_cycle[m] = 1'b0; wbm_strobe[m] = 1'b0; wbm_write[m] = 1'b0;
                end
            end
        end
        if (got < n) begin
            check($sformatf("m%0d_timeout_acks", m), got, n);
            wbm_cycle[m] = 1'b0; wbm_strobe[m] = 1'b0; wbm_write[m] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        wbm_address = '0; wbm_writedata = '0;
        wbm_strobe = '0; wbm_cycle = '0; wbm_write = '0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_ds_cycle", wbs_sdram_cycle, 0);
        check("rst_ds_address", wbs_sdram_address, 0);
        check("rst_wbm_ack", wbm_ack, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: single write from master 0
        @(posedge clk);
        #1;
        wbm_cycle[0] = 1'b1; wbm_strobe[0] = 1'b1; wbm_write[0] = 1'b1;
        wbm_address[0 +: AW] = 32'h100; wbm_writedata[0 +: DW] = 16'hA5A5;
        @(negedge clk);
        check("t1_cycle_same_clk", wbs_sdram_cycle, 0);
        @(negedge clk);
        check("t1_cycle_after_1clk", wbs_sdram_cycle, 1);
        check("t1_grant_idx", grant_idx, 0);
        check("t1_address", wbs_sdram_address, 32'h100);
        check("t1_writedata", wbs_sdram_writedata, 16'hA5A5);
        check("t1_write", wbs_sdram_write, 1);
        n = 0;
        while (!wbm_ack[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_ack_latency", n, 3);
        check("t1_wbm_ack", wbm_ack, 2'b01);
        @(posedge clk);
        #1 wbm_cycle[0] = 1'b0; wbm_strobe[0] = 1'b0; wbm_write[0] = 1'b0;
        repeat (3) @(negedge clk);

        // 2: simultaneous request after reset, master 0 first
        do_reset();
        glog.delete(); alog.delete();
        fork
            master_run(0, 1, 1'b0, 32'h200);
            master_run(1, 1, 1'b0, 32'h300);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(grant_valid && grant_idx == 0 && !wbm_cycle[0]) && n < 50);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(grant_valid && grant_idx == 1 && wbs_sdram_cycle) && n < 50);
                check("t2_m1_grant_after_m0_drop", n, 3);
            end
        join
        check("t2_grants", glog.size(), 2);
        check("t2_first", glog[0], 0);
        check("t2_second", glog[1], 1);

        // 3: continuous single transfers alternate
        glog.delete(); alog.delete();
        fork
            begin master_run(0, 1, 1'b0, 32'h400); master_run(0, 1, 1'b1, 32'h410); end
            begin master_run(1, 1, 1'b1, 32'h500); master_run(1, 1, 1'b0, 32'h510); end
        join
        repeat (3) @(negedge clk);
        check("t3_grants", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_grant_%0d", i), glog[i], i % 2);

        // 4: burst pre-empted after MAX_HOLD acks
        glog.delete(); alog.delete();
        fork
            master_run(0, 10, 1'b0, 32'h1000);
            begin repeat (3) @(posedge clk); master_run(1, 1, 1'b0, 32'h2000); end
        join
        repeat (3) @(negedge clk);
        check("t4_grants", glog.size(), 3);
        check("t4_grant_0", glog[0], 0);
        check("t4_grant_1", glog[1], 1);
        check("t4_grant_2", glog[2], 0);
        check("t4_acks_0", alog[0], 4);
        check("t4_acks_1", alog[1], 1);
        check("t4_acks_2", alog[2], 6);

        // 5: granted master drops before any ack
        glog.delete(); alog.delete();
        @(posedge clk);
        #1;
        wbm_cycle[0] = 1'b1; wbm_strobe[0] = 1'b1; wbm_address[0 +: AW] = 32'h600;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_sdram_cycle && n < 20);
        check("t5_granted", wbs_sdram_cycle, 1);
        @(posedge clk);
        #1 wbm_cycle[0] = 1'b0; wbm_strobe[0] = 1'b0;
        @(negedge clk);
        check("t5_ds_cycle_drop", wbs_sdram_cycle, 0);
        @(negedge clk);
        check("t5_release_valid", grant_valid, 1);
        check("t5_release_cycle", wbs_sdram_cycle, 0);
        @(negedge clk);
        check("t5_idle_valid", grant_valid, 0);
        repeat (3) @(negedge clk);
        check("t5_no_ack", alog[0], 0);

        // 6: reset while master 1 is mid-read
        @(posedge clk);
        #1;
        wbm_cycle[1] = 1'b1; wbm_strobe[1] = 1'b1; wbm_address[AW +: AW] = 32'h3000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wbs_sdram_cycle && grant_idx == 1) && n < 20);
        check("t6_m1_granted", grant_idx, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wbm_cycle[0] = 1'b1; wbm_strobe[0] = 1'b1; wbm_address[0 +: AW] = 32'h3100;
        @(negedge clk);
        check("t6_rst_ds_cycle", wbs_sdram_cycle, 0);
        check("t6_rst_ds_strobe", wbs_sdram_strobe, 0);
        check("t6_rst_ds_address", wbs_sdram_address, 0);
        check("t6_rst_grant_valid", grant_valid, 0);
        check("t6_rst_wbm_ack", wbm_ack, 0);
        check("t6_rst_readdata", wbm_readdata, 0);
        @(negedge clk);
        check("t6_m0_wins_valid", grant_valid, 1);
        check("t6_m0_wins_idx", grant_idx, 0);
        check("t6_m0_ds_address", wbs_sdram_address, 32'h3100);
        @(posedge clk);
        #1 wbm_cycle = '0; wbm_strobe = '0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
